// File: rtl/cf_fft_1024_8_seq_if.sv
// Handshake/status bundle between the frame sequencer and the FFT datapath.
// CF_FFT_BITREV_EN (see the sequencer) only changes how addr_o is encoded.
interface cf_fft_1024_8_seq_if #(
    parameter int unsigned LOG2N = 10
);
    logic             enable_i;
    logic             sync_i;
    logic [1:0]       phase_o;
    logic [LOG2N-1:0] addr_o;
    logic             busy_o;
    logic             last_o;
    logic             sync_o;
    logic             err_o;
    logic [7:0]       frames_o;

    modport master (
        output enable_i, sync_i,
        input  phase_o, addr_o, busy_o, last_o, sync_o, err_o, frames_o
    );

    modport slave (
        input  enable_i, sync_i,
        output phase_o, addr_o, busy_o, last_o, sync_o, err_o, frames_o
    );
endinterface

// File: rtl/cf_fft_1024_8_seq.sv
// Frame sequencer for the 1024-point FFT: sample counter, phase code, frame strobes, sync delay.
// Define CF_FFT_BITREV_EN to present addr_o in bit-reversed (output-reorder) order.
module cf_fft_1024_8_seq #(
    parameter int unsigned LOG2N   = 10,
    parameter int unsigned LATENCY = 8
) (
    input logic                clock_c,
    input logic                reset_i,
    cf_fft_1024_8_seq_if.slave bus
);
    localparam logic [LOG2N-1:0] CntMax = '1;
    localparam logic [LOG2N-1:0] CntOne = LOG2N'(1);

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    state_e             state_q, state_d;
    logic [LOG2N-1:0]   cnt_q, cnt_d;
    logic               err_q, err_d;
    logic [7:0]         frames_q, frames_d;
    logic [LATENCY-1:0] dly_q;
    logic               sync_q;

    logic               busy_q, busy_d;
    logic               last_q, last_d;
    logic [1:0]         phase_q, phase_d;
    logic [LOG2N-1:0]   addr_q, addr_d;
    logic [LOG2N-1:0]   addr_map;

    // State register: everything advances only on enabled cycles; reset wins over enable.
    always_ff @(posedge clock_c) begin
        if (reset_i) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            err_q    <= 1'b0;
            frames_q <= '0;
            dly_q    <= '0;
            sync_q   <= 1'b0;
            busy_q   <= 1'b0;
            last_q   <= 1'b0;
            phase_q  <= '0;
            addr_q   <= '0;
        end else if (bus.enable_i) begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
            frames_q <= frames_d;
            dly_q[0] <= bus.sync_i;
            for (int i = 1; i < int'(LATENCY); i++) begin
                dly_q[i] <= dly_q[i-1];
            end
            sync_q   <= dly_q[LATENCY-1];
            busy_q   <= busy_d;
            last_q   <= last_d;
            phase_q  <= phase_d;
            addr_q   <= addr_d;
        end
    end

    // Next state: a sync at the final sample is a back-to-back start, not an error.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        err_d    = err_q;
        frames_d = frames_q;
        unique case (state_q)
            StIdle: begin
                if (bus.sync_i) begin
                    state_d = StRun;
                    cnt_d   = '0;
                end
            end
            StRun: begin
                if (cnt_q == CntMax) begin
                    frames_d = frames_q + 8'd1;
                    cnt_d    = '0;
                    if (!bus.sync_i) begin
                        state_d = StIdle;
                    end
                end else if (bus.sync_i) begin
                    cnt_d = '0;
                    err_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CntOne;
                end
            end
        endcase
    end

    always_comb begin
        addr_map = '0;
`ifdef CF_FFT_BITREV_EN
        for (int k = 0; k < int'(LOG2N); k++) begin
            addr_map[k] = cnt_q[LOG2N-1-k];
        end
`else
        addr_map = cnt_q;
`endif
    end

    // Output decode from the current state; registered on the next enabled edge.
    always_comb begin
        busy_d  = 1'b0;
        last_d  = 1'b0;
        phase_d = '0;
        addr_d  = '0;
        if (state_q == StRun) begin
            busy_d  = 1'b1;
            last_d  = (cnt_q == CntMax);
            phase_d = cnt_q[1:0];
            addr_d  = addr_map;
        end
    end

    assign bus.busy_o   = busy_q;
    assign bus.last_o   = last_q;
    assign bus.phase_o  = phase_q;
    assign bus.addr_o   = addr_q;
    assign bus.sync_o   = sync_q;
    assign bus.err_o    = err_q;
    assign bus.frames_o = frames_q;
endmodule
